// File: rtl/async_fifo_pro.sv
// Dual-clock FIFO with gray-coded pointer crossing, registered status flags,
// programmable almost-full/almost-empty thresholds and an optional FWFT read port.
module async_fifo_pro #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SHOWAHEAD   = 0
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  afull,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  overflow,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    input  logic                  udf_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic {OUT_EMPTY, OUT_VALID} out_state_e;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    ptr_t wr_bin, wr_gray, wr_bin_nxt, wr_gray_nxt, wr_count_nxt, rd_gray_s;
    ptr_t rd_gray_sync [SYNC_STAGES];
    ptr_t rd_gray;
    logic wr_vld;

    assign wr_vld       = wr_en & ~full;
    assign wr_bin_nxt   = wr_bin + ptr_t'(wr_vld);
    assign wr_gray_nxt  = bin2gray(wr_bin_nxt);
    assign rd_gray_s    = rd_gray_sync[SYNC_STAGES-1];
    assign wr_count_nxt = wr_bin_nxt - gray2bin(rd_gray_s);

    // NOTE: the storage array has no reset; contents are only meaningful behind
    // the pointers, and leaving it unreset lets it map onto plain flops/LUT RAM.
    always_ff @(posedge wr_clk) begin
        if (wr_vld) mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin   <= '0;
            wr_gray  <= '0;
            full     <= 1'b0;
            afull    <= 1'b0;
            wr_count <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) rd_gray_sync[i] <= '0;
        end else begin
            wr_bin          <= wr_bin_nxt;
            wr_gray         <= wr_gray_nxt;
            rd_gray_sync[0] <= rd_gray;
            for (int i = 1; i < SYNC_STAGES; i++) rd_gray_sync[i] <= rd_gray_sync[i-1];
            // Full when the write pointer is one lap ahead: top two gray bits inverted.
            full     <= (wr_gray_nxt == {~rd_gray_s[PW-1:PW-2], rd_gray_s[PW-3:0]});
            wr_count <= wr_count_nxt;
            afull    <= (wr_count_nxt >= afull_thresh);
            overflow <= (wr_en & full) | (overflow & ~ovf_clr);
        end
    end

    // ---------------- read domain ----------------
    ptr_t rd_bin, rd_bin_nxt, rd_gray_nxt, wr_gray_s, rd_count_nxt;
    ptr_t wr_gray_sync [SYNC_STAGES];
    logic ram_empty, rd_adv, out_valid_nxt;

    assign wr_gray_s    = wr_gray_sync[SYNC_STAGES-1];
    assign rd_bin_nxt   = rd_bin + ptr_t'(rd_adv);
    assign rd_gray_nxt  = bin2gray(rd_bin_nxt);
    assign rd_count_nxt = gray2bin(wr_gray_s) - rd_bin_nxt + ptr_t'(out_valid_nxt);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin    <= '0;
            rd_gray   <= '0;
            ram_empty <= 1'b1;
            aempty    <= 1'b1;
            rd_count  <= '0;
            underflow <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) wr_gray_sync[i] <= '0;
        end else begin
            rd_bin          <= rd_bin_nxt;
            rd_gray         <= rd_gray_nxt;
            wr_gray_sync[0] <= wr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) wr_gray_sync[i] <= wr_gray_sync[i-1];
            ram_empty <= (rd_gray_nxt == wr_gray_s);
            rd_count  <= rd_count_nxt;
            aempty    <= (rd_count_nxt <= aempty_thresh);
            underflow <= (rd_en & empty) | (underflow & ~udf_clr);
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_fwft
            out_state_e out_state;

            // Prefetch whenever the output register is free or being acknowledged.
            assign rd_adv        = ~ram_empty & ((out_state == OUT_EMPTY) | rd_en);
            assign out_valid_nxt = rd_adv | ((out_state == OUT_VALID) & ~rd_en);
            assign empty         = (out_state == OUT_EMPTY);

            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) begin
                    out_state <= OUT_EMPTY;
                    rd_data   <= '0;
                end else if (rd_adv) begin
                    out_state <= OUT_VALID;
                    rd_data   <= mem[rd_bin[ADDR_WIDTH-1:0]];
                end else if (rd_en) begin
                    out_state <= OUT_EMPTY;
                end
            end
        end else begin : g_std
            assign rd_adv        = rd_en & ~ram_empty;
            assign out_valid_nxt = 1'b0;
            assign empty         = ram_empty;

            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) rd_data <= '0;
                else if (rd_adv) rd_data <= mem[rd_bin[ADDR_WIDTH-1:0]];
            end
        end
    endgenerate
endmodule

// File: tb/tb_async_fifo_pro.sv
// Self-checking bench for async_fifo_pro: standard and FWFT instances, scoreboard
// queues for data ordering, a threshold vector table and hand-written corner cases.
`timescale 1ns / 1ps
module tb_async_fifo_pro;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          wr_rst_n, rd_rst_n;
    logic          wr_en, rd_en, fw_wr_en, fw_rd_en, ovf_clr, udf_clr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   afull_thresh, aempty_thresh;

    logic          full, afull, overflow, empty, aempty, underflow;
    logic [AW:0]   wr_count, rd_count;
    logic [DW-1:0] rd_data;
    logic          fw_full, fw_afull, fw_overflow, fw_empty, fw_aempty, fw_underflow;
    logic [AW:0]   fw_wr_count, fw_rd_count;
    logic [DW-1:0] fw_rd_data;

    always #5 wr_clk = ~wr_clk;
    always #13.5135 rd_clk = ~rd_clk;

    async_fifo_pro #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2), .SHOWAHEAD(0)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .afull_thresh(afull_thresh), .ovf_clr(ovf_clr),
        .full(full), .afull(afull), .wr_count(wr_count), .overflow(overflow),
        .rd_en(rd_en), .aempty_thresh(aempty_thresh), .udf_clr(udf_clr),
        .rd_data(rd_data), .empty(empty), .aempty(aempty), .rd_count(rd_count),
        .underflow(underflow)
    );

    async_fifo_pro #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2), .SHOWAHEAD(1)) dut_fwft (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .wr_en(fw_wr_en), .wr_data(wr_data), .afull_thresh(afull_thresh), .ovf_clr(ovf_clr),
        .full(fw_full), .afull(fw_afull), .wr_count(fw_wr_count), .overflow(fw_overflow),
        .rd_en(fw_rd_en), .aempty_thresh(aempty_thresh), .udf_clr(udf_clr),
        .rd_data(fw_rd_data), .empty(fw_empty), .aempty(fw_aempty), .rd_count(fw_rd_count),
        .underflow(fw_underflow)
    );

    typedef struct {
        logic [AW:0] af_th;
        logic        exp_afull;
        logic [AW:0] ae_th;
        logic        exp_aempty;
    } thr_vec_t;

    thr_vec_t      thr_vec [4];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] fw_sb [$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_wait, w_sent, r_got, both_err, w_guard, r_guard;
    logic          r_had;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wr_push(input logic [DW-1:0] d);
        @(negedge wr_clk);
        wr_en   = 1'b1;
        wr_data = d;
        if (!full) sb.push_back(d);
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic fw_push(input logic [DW-1:0] d);
        @(negedge wr_clk);
        fw_wr_en = 1'b1;
        wr_data  = d;
        if (!fw_full) fw_sb.push_back(d);
        @(posedge wr_clk); #1;
        fw_wr_en = 1'b0;
    endtask

    task automatic rd_pop(input string name);
        logic had;
        @(negedge rd_clk);
        had   = !empty;
        rd_en = 1'b1;
        @(posedge rd_clk); #1;
        rd_en = 1'b0;
        if (had) begin
            if (sb.size() == 0) check({name, "_sb_underrun"}, 32'(sb.size()), 1);
            else check(name, 32'(rd_data), 32'(sb.pop_front()));
        end
    endtask

    task automatic check_reset(input string t);
        check({t, "_rd_data"},   32'(rd_data),   0);
        check({t, "_empty"},     32'(empty),     1);
        check({t, "_aempty"},    32'(aempty),    1);
        check({t, "_rd_count"},  32'(rd_count),  0);
        check({t, "_underflow"}, 32'(underflow), 0);
        check({t, "_full"},      32'(full),      0);
        check({t, "_afull"},     32'(afull),     0);
        check({t, "_wr_count"},  32'(wr_count),  0);
        check({t, "_overflow"},  32'(overflow),  0);
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; fw_wr_en = 1'b0; fw_rd_en = 1'b0;
        ovf_clr = 1'b0; udf_clr = 1'b0;
        wr_rst_n = 1'b0; rd_rst_n = 1'b0;
        #40;
        sb.delete();
        fw_sb.delete();
        wr_rst_n = 1'b1; rd_rst_n = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // With wr_count = rd_count = 16 held steady
        thr_vec[0] = '{5'd15, 1'b1, 5'd15, 1'b0};
        thr_vec[1] = '{5'd16, 1'b1, 5'd16, 1'b1};
        thr_vec[2] = '{5'd17, 1'b0, 5'd0,  1'b0};
        thr_vec[3] = '{5'd0,  1'b1, 5'd31, 1'b1};

        wr_en = 1'b0; rd_en = 1'b0; fw_wr_en = 1'b0; fw_rd_en = 1'b0;
        ovf_clr = 1'b0; udf_clr = 1'b0; wr_data = '0;
        afull_thresh = 5'd15; aempty_thresh = 5'd3;
        wr_rst_n = 1'b0; rd_rst_n = 1'b0;
        #30;
        check_reset("rst");
        wr_rst_n = 1'b1; rd_rst_n = 1'b1;
        repeat (3) @(posedge rd_clk);
        #1;

        // Fill 16 words
        for (int i = 0; i < 16; i++) wr_push(8'(i));
        check("fill_full",     32'(full),     1);
        check("fill_wr_count", 32'(wr_count), 16);
        check("fill_afull15",  32'(afull),    1);

        // Overflow: dropped write, clear, then set-wins-over-clear
        wr_push(8'hAA);
        check("ovf_set",      32'(overflow), 1);
        check("ovf_wr_count", 32'(wr_count), 16);
        @(negedge wr_clk); ovf_clr = 1'b1;
        @(posedge wr_clk); #1; ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);
        @(negedge wr_clk); ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
        @(posedge wr_clk); #1; ovf_clr = 1'b0; wr_en = 1'b0;
        check("ovf_set_wins", 32'(overflow), 1);
        @(negedge wr_clk); ovf_clr = 1'b1;
        @(posedge wr_clk); #1; ovf_clr = 1'b0;
        check("ovf_clr2", 32'(overflow), 0);

        repeat (6) @(posedge rd_clk);
        #1;
        check("rd_sees_empty",  32'(empty),    0);
        check("rd_sees_count",  32'(rd_count), 16);
        check("rd_sees_aempty", 32'(aempty),   0);

        for (int v = 0; v < 4; v++) begin
            afull_thresh  = thr_vec[v].af_th;
            aempty_thresh = thr_vec[v].ae_th;
            repeat (3) @(posedge rd_clk);
            #1;
            check($sformatf("thr%0d_afull", v),  32'(afull),  32'(thr_vec[v].exp_afull));
            check($sformatf("thr%0d_aempty", v), 32'(aempty), 32'(thr_vec[v].exp_aempty));
        end
        afull_thresh = 5'd15; aempty_thresh = 5'd3;
        repeat (3) @(posedge rd_clk);

        // Drain 17 reads
        for (int i = 0; i < 16; i++) rd_pop($sformatf("drain%0d", i));
        check("drain_empty",    32'(empty),    1);
        check("drain_rd_count", 32'(rd_count), 0);
        check("drain_aempty",   32'(aempty),   1);
        check("drain_sb_left",  32'(sb.size()), 0);
        rd_pop("drain16");
        check("udf_set",     32'(underflow), 1);
        check("udf_rd_hold", 32'(rd_data),   8'h0F);
        @(negedge rd_clk); udf_clr = 1'b1;
        @(posedge rd_clk); #1; udf_clr = 1'b0;
        check("udf_clr", 32'(underflow), 0);
        repeat (4) @(posedge wr_clk);
        #1;
        check("drain_full_fall", 32'(full),     0);
        check("drain_wr_count",  32'(wr_count), 0);
        check("drain_afull",     32'(afull),    0);

        // aempty threshold crossing
        for (int i = 0; i < 4; i++) wr_push(8'(8'h10 + i));
        repeat (6) @(posedge rd_clk);
        #1;
        check("ae_after4",  32'(aempty),   0);
        check("ae_count4",  32'(rd_count), 4);
        rd_pop("ae_read1");
        check("ae_after_rd", 32'(aempty),   1);
        check("ae_count3",   32'(rd_count), 3);

        // Both resets asserted mid-stream
        @(negedge wr_clk); wr_en = 1'b1; wr_data = 8'h77;
        #3;
        wr_rst_n = 1'b0; rd_rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        do_reset();

        // Wrap: 100 words, random enables on both sides
        w_sent = 0; r_got = 0; both_err = 0; w_guard = 0; r_guard = 0;
        fork
            begin
                while (w_sent < 100 && w_guard < 20000) begin
                    @(negedge wr_clk);
                    wr_en   = 1'($urandom_range(0, 1));
                    wr_data = w_sent[7:0];
                    if (wr_en && !full) begin
                        sb.push_back(wr_data);
                        w_sent++;
                    end
                    w_guard++;
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                while (r_got < 100 && r_guard < 5000) begin
                    @(negedge rd_clk);
                    rd_en = 1'($urandom_range(0, 1));
                    r_had = rd_en && !empty;
                    @(posedge rd_clk); #1;
                    if (full && empty) both_err++;
                    if (r_had) begin
                        if (sb.size() == 0) check("wrap_sb_underrun", 32'(sb.size()), 1);
                        else check($sformatf("wrap_data%0d", r_got), 32'(rd_data), 32'(sb.pop_front()));
                        r_got++;
                    end
                    r_guard++;
                end
                rd_en = 1'b0;
            end
        join
        check("wrap_words_read",     32'(r_got),    100);
        check("wrap_full_and_empty", 32'(both_err), 0);

        // FWFT instance
        do_reset();
        check("fw_rst_rd_data",   32'(fw_rd_data),   0);
        check("fw_rst_empty",     32'(fw_empty),     1);
        check("fw_rst_aempty",    32'(fw_aempty),    1);
        check("fw_rst_rd_count",  32'(fw_rd_count),  0);
        check("fw_rst_underflow", 32'(fw_underflow), 0);
        check("fw_rst_full",      32'(fw_full),      0);
        check("fw_rst_afull",     32'(fw_afull),     0);
        check("fw_rst_wr_count",  32'(fw_wr_count),  0);
        check("fw_rst_overflow",  32'(fw_overflow),  0);

        fw_push(8'h5C);
        n_wait = 0;
        while (fw_empty && n_wait < 10) begin
            @(posedge rd_clk); #1;
            n_wait++;
        end
        check("fwft_empty_fall",  32'(fw_empty),     0);
        check("fwft_latency_le5", 32'(n_wait <= 5),  1);
        check("fwft_data",        32'(fw_rd_data),   8'h5C);
        check("fwft_rd_count",    32'(fw_rd_count),  1);
        void'(fw_sb.pop_front());
        @(negedge rd_clk); fw_rd_en = 1'b1;
        @(posedge rd_clk); #1; fw_rd_en = 1'b0;
        check("fwft_empty_after_ack", 32'(fw_empty),    1);
        check("fwft_count_after_ack", 32'(fw_rd_count), 0);

        for (int i = 0; i < 3; i++) fw_push(8'(8'h31 + i));
        repeat (8) @(posedge rd_clk);
        #1;
        check("fwft_rd_count3", 32'(fw_rd_count), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fwft_multi_vld%0d", i), 32'(fw_empty), 0);
            check($sformatf("fwft_multi_data%0d", i), 32'(fw_rd_data), 32'(fw_sb.pop_front()));
            @(negedge rd_clk); fw_rd_en = 1'b1;
            @(posedge rd_clk); #1; fw_rd_en = 1'b0;
        end
        check("fwft_multi_empty", 32'(fw_empty), 1);
        @(negedge rd_clk); fw_rd_en = 1'b1;
        @(posedge rd_clk); #1; fw_rd_en = 1'b0;
        check("fwft_underflow", 32'(fw_underflow), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
